// File: rtl/multisim_client_apb_pull_buffered.sv
// Buffered APB manager that pulls requests from a multisim server and
// pushes responses back, with request/response FIFOs, timeout and counters.

module multisim_client_apb_pull_buffered_fifo #(
    parameter type T = logic,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T           mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= inc(wp);
            if (pop) rp <= inc(rp);
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_comb begin
        head  = mem[rp];
        full  = (cnt == CW'(DEPTH));
        empty = (cnt == '0);
    end
endmodule

// Request channel endpoint; the server side deposits entries via offer().
module multisim_client_apb_pull_buffered_pull #(
    parameter type T = logic,
    parameter bit FOUR_STATE = 1'b0
) (
    input  logic  clk,
    input  string server_runtime_directory,
    input  string channel,
    input  logic  rdy,
    output logic  vld,
    output T      data
);
    logic active;
    logic pend_vld;
    T     pend_data;
    bit [$bits(T)-1:0] two;

    always_ff @(posedge clk) begin
        active <= (server_runtime_directory.len() != 0) && (channel.len() != 0);
    end

    always_comb begin
        two  = pend_data;
        vld  = active && pend_vld;
        data = FOUR_STATE ? pend_data : T'(two);
    end

    task offer(input logic v, input T d);
        pend_vld  = v;
        pend_data = d;
    endtask

    function logic accepted();
        return pend_vld && active && rdy;
    endfunction
endmodule

module multisim_client_apb_pull_buffered_push #(
    parameter type T = logic,
    parameter bit FOUR_STATE = 1'b0
) (
    input  logic  clk,
    input  string server_runtime_directory,
    input  string channel,
    input  logic  vld,
    input  T      data,
    output logic  rdy
);
    logic active;
    logic pend_rdy;
    bit [$bits(T)-1:0] two;

    always_ff @(posedge clk) begin
        active <= (server_runtime_directory.len() != 0) && (channel.len() != 0);
    end

    always_comb begin
        two = data;
        rdy = active && pend_rdy;
    end

    task set_rdy(input logic r);
        pend_rdy = r;
    endtask

    function logic fire();
        return vld && active && pend_rdy;
    endfunction

    function T peek();
        return FOUR_STATE ? data : T'(two);
    endfunction
endmodule

module multisim_client_apb_pull_buffered #(
    parameter type apb_req_t = logic [31:0],
    parameter type apb_resp_t = logic [31:0],
    parameter bit DATA_IS_4STATE = 1'b0,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int RESP_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter apb_resp_t TIMEOUT_RESP = '1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  string                server_runtime_directory,
    input  string                server_name,
    output apb_req_t             o_apb_m_req,
    input  apb_resp_t            i_apb_m_resp,
    output logic                 o_apb_m_psel,
    output logic                 o_apb_m_penable,
    input  logic                 i_apb_m_pready,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_txn_count,
    output logic [CNT_WIDTH-1:0] o_timeout_count
);
    localparam int RQW = $clog2(REQ_FIFO_DEPTH + 1);
    localparam int RSW = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int WW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state, state_next;
    logic [WW-1:0] wait_cnt, wait_next;

    logic chan_clk;
    logic req_vld, req_rdy, req_push, req_pop, req_full, req_empty;
    logic resp_rdy, resp_vld, resp_push, resp_pop, resp_full, resp_empty;
    logic done, tmo, can_start, can_start_next;
    logic [RQW-1:0] req_cnt, req_cnt_next;
    logic [RSW-1:0] resp_cnt, resp_cnt_next;
    apb_req_t  req_data, req_head;
    apb_resp_t resp_din, resp_head;

    assign chan_clk = clk & ~rst;

    multisim_client_apb_pull_buffered_pull #(
        .T(apb_req_t), .FOUR_STATE(DATA_IS_4STATE)
    ) u_req (
        .clk(chan_clk),
        .server_runtime_directory(server_runtime_directory),
        .channel({server_name, "_apb_req"}),
        .rdy(req_rdy),
        .vld(req_vld),
        .data(req_data)
    );

    multisim_client_apb_pull_buffered_push #(
        .T(apb_resp_t), .FOUR_STATE(DATA_IS_4STATE)
    ) u_resp (
        .clk(chan_clk),
        .server_runtime_directory(server_runtime_directory),
        .channel({server_name, "_apb_resp"}),
        .vld(resp_vld),
        .data(resp_head),
        .rdy(resp_rdy)
    );

    multisim_client_apb_pull_buffered_fifo #(
        .T(apb_req_t), .DEPTH(REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk(clk), .rst(rst), .push(req_push), .din(req_data),
        .pop(req_pop), .head(req_head), .cnt(req_cnt),
        .full(req_full), .empty(req_empty)
    );

    multisim_client_apb_pull_buffered_fifo #(
        .T(apb_resp_t), .DEPTH(RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk(clk), .rst(rst), .push(resp_push), .din(resp_din),
        .pop(resp_pop), .head(resp_head), .cnt(resp_cnt),
        .full(resp_full), .empty(resp_empty)
    );

    always_comb begin
        done = 1'b0;
        tmo  = 1'b0;
        if (state == ACCESS) begin
            if (i_apb_m_pready) begin
                done = 1'b1;
            end else if (TIMEOUT_CYCLES > 0 &&
                         wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                done = 1'b1;
                tmo  = 1'b1;
            end
        end
    end

    always_comb begin
        req_rdy   = !req_full;
        req_push  = req_vld && req_rdy;
        req_pop   = done;
        resp_vld  = !resp_empty;
        resp_pop  = resp_vld && resp_rdy;
        resp_push = done;
        resp_din  = tmo ? TIMEOUT_RESP : i_apb_m_resp;
        req_cnt_next  = req_cnt + RQW'(req_push) - RQW'(req_pop);
        resp_cnt_next = resp_cnt + RSW'(resp_push) - RSW'(resp_pop);
        can_start      = !req_empty && !resp_full;
        can_start_next = (req_cnt_next != '0) &&
                         (resp_cnt_next != RSW'(RESP_FIFO_DEPTH));
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        unique case (state)
            IDLE: begin
                if (can_start) state_next = SETUP;
            end
            SETUP: begin
                state_next = ACCESS;
                wait_next  = '0;
            end
            ACCESS: begin
                if (tmo) state_next = IDLE;
                else if (done) state_next = can_start_next ? SETUP : IDLE;
                else wait_next = wait_cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            o_txn_count     <= '0;
            o_timeout_count <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            // Saturate rather than wrap
            if (done && o_txn_count != '1) o_txn_count <= o_txn_count + 1'b1;
            if (tmo && o_timeout_count != '1)
                o_timeout_count <= o_timeout_count + 1'b1;
        end
    end

    always_comb begin
        o_apb_m_psel    = (state != IDLE);
        o_apb_m_penable = (state == ACCESS);
        o_apb_m_req     = (state == IDLE) ? '0 : req_head;
        o_busy          = !req_empty || !resp_empty || (state != IDLE);
    end
endmodule

// File: tb/tb_multisim_client_apb_pull_buffered.sv
// Directed bench: single, burst, wait states, back-pressure, timeout,
// limit-cycle completion and reset in ACCESS.

module tb_multisim_client_apb_pull_buffered;
    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    req_t        req;
    resp_t       resp = '0;
    logic        psel, penable;
    logic        pready = 1'b0;
    logic        busy;
    logic [31:0] txn, tmo;
    string       dir = "/tmp/ms_run";
    string       name = "apb0";

    int checks = 0;
    int errors = 0;
    req_t  req_q[$];
    resp_t got_q[$];
    logic  pend = 1'b0;
    int    delay = 0;
    int    acc = 0;
    int    nsave;

    always #5 clk = ~clk;

    multisim_client_apb_pull_buffered #(
        .apb_req_t(req_t),
        .apb_resp_t(resp_t),
        .DATA_IS_4STATE(1'b0),
        .REQ_FIFO_DEPTH(4),
        .RESP_FIFO_DEPTH(2),
        .TIMEOUT_CYCLES(5),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .server_runtime_directory(dir),
        .server_name(name),
        .o_apb_m_req(req),
        .i_apb_m_resp(resp),
        .o_apb_m_psel(psel),
        .o_apb_m_penable(penable),
        .i_apb_m_pready(pready),
        .o_busy(busy),
        .o_txn_count(txn),
        .o_timeout_count(tmo)
    );

    function automatic req_t mk(input int i);
        req_t r;
        r.addr  = 16'(32'h1000 + i * 4);
        r.write = i[0];
        r.wdata = 32'hC0DE0000 + 32'(i);
        r.strb  = 4'hF;
        r.prot  = 3'b000;
        return r;
    endfunction

    function automatic resp_t want(input req_t r, input int k);
        resp_t s;
        s.rdata  = {8'hA5, 8'(k), r.addr};
        s.slverr = 1'b0;
        return s;
    endfunction

    // Server side of the request channel
    always @(negedge clk) begin
        if (pend && req_q.size() != 0) void'(req_q.pop_front());
        if (!rst && req_q.size() != 0) dut.u_req.offer(1'b1, req_q[0]);
        else dut.u_req.offer(1'b0, '0);
        pend = !rst && dut.u_req.accepted();
    end

    // Subordinate: PREADY after 'delay' ACCESS cycles, rdata tags the cycle
    always @(negedge clk) begin
        if (psel && penable) acc = acc + 1;
        else acc = 0;
        pready = psel && penable && (acc > delay);
        resp = want(req, acc);
    end

    always @(negedge clk) begin
        if (!rst && dut.u_resp.fire()) got_q.push_back(dut.u_resp.peek());
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_psel(input string tag);
        int n = 0;
        while (psel !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(psel), 64'd1);
    endtask

    initial begin
        dut.u_resp.set_rdy(1'b1);
        dut.u_req.offer(1'b0, '0);
        rst = 1'b1;
        tick(3);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_txn", 64'(txn), 64'd0);
        chk("rst_tmo", 64'(tmo), 64'd0);
        rst = 1'b0;
        tick(2);

        req_q.push_back(mk(0));
        tick(1);
        chk("single_idle", 64'(psel), 64'd0);
        chk("single_busy", 64'(busy), 64'd1);
        tick(1);
        chk("single_setup_psel", 64'(psel), 64'd1);
        chk("single_setup_pen", 64'(penable), 64'd0);
        chk("single_setup_req", 64'(req), 64'(mk(0)));
        tick(1);
        chk("single_access_pen", 64'(penable), 64'd1);
        chk("single_access_req", 64'(req), 64'(mk(0)));
        tick(1);
        chk("single_done_psel", 64'(psel), 64'd0);
        chk("single_txn", 64'(txn), 64'd1);
        tick(2);
        chk("single_nresp", 64'(got_q.size()), 64'd1);
        chk("single_resp", 64'(got_q[0]), 64'(want(mk(0), 1)));
        chk("single_idle_busy", 64'(busy), 64'd0);

        for (int i = 1; i <= 8; i++) req_q.push_back(mk(i));
        wait_psel("burst_start");
        for (int i = 0; i < 16; i++) begin
            chk("burst_psel", 64'(psel), 64'd1);
            chk("burst_pen", 64'(penable), 64'(i % 2));
            chk("burst_req", 64'(req), 64'(mk(1 + i / 2)));
            tick(1);
        end
        chk("burst_end_psel", 64'(psel), 64'd0);
        chk("burst_txn", 64'(txn), 64'd9);
        tick(3);
        chk("burst_nresp", 64'(got_q.size()), 64'd9);
        for (int i = 1; i <= 8; i++)
            chk("burst_resp", 64'(got_q[i]), 64'(want(mk(i), 1)));

        delay = 3;
        req_q.push_back(mk(9));
        wait_psel("wait_start");
        for (int i = 0; i < 5; i++) begin
            chk("wait_req", 64'(req), 64'(mk(9)));
            chk("wait_pen", 64'(penable), 64'(i != 0));
            tick(1);
        end
        chk("wait_end_psel", 64'(psel), 64'd0);
        tick(2);
        chk("wait_nresp", 64'(got_q.size()), 64'd10);
        chk("wait_resp", 64'(got_q[9]), 64'(want(mk(9), 4)));
        chk("wait_txn", 64'(txn), 64'd10);

        delay = 0;
        dut.u_resp.set_rdy(1'b0);
        for (int i = 10; i <= 13; i++) req_q.push_back(mk(i));
        tick(14);
        chk("bp_psel", 64'(psel), 64'd0);
        chk("bp_txn", 64'(txn), 64'd12);
        chk("bp_nresp", 64'(got_q.size()), 64'd10);
        chk("bp_busy", 64'(busy), 64'd1);
        dut.u_resp.set_rdy(1'b1);
        tick(20);
        chk("bp_resume_nresp", 64'(got_q.size()), 64'd14);
        for (int i = 10; i <= 13; i++)
            chk("bp_resp", 64'(got_q[i]), 64'(want(mk(i), 1)));
        chk("bp_resume_txn", 64'(txn), 64'd14);
        chk("bp_resume_busy", 64'(busy), 64'd0);

        delay = 1000;
        req_q.push_back(mk(14));
        wait_psel("tmo_start");
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("tmo_access", 64'({psel, penable}), 64'd3);
            tick(1);
        end
        chk("tmo_drop", 64'(psel), 64'd0);
        chk("tmo_count", 64'(tmo), 64'd1);
        chk("tmo_txn", 64'(txn), 64'd15);
        tick(2);
        chk("tmo_nresp", 64'(got_q.size()), 64'd15);
        chk("tmo_resp", 64'(got_q[14]), 64'h1_FFFF_FFFF);
        delay = 0;
        req_q.push_back(mk(15));
        tick(6);
        chk("after_tmo_resp", 64'(got_q[15]), 64'(want(mk(15), 1)));
        chk("after_tmo_count", 64'(tmo), 64'd1);
        chk("after_tmo_txn", 64'(txn), 64'd16);

        delay = 4;
        req_q.push_back(mk(16));
        tick(12);
        chk("limit_resp", 64'(got_q[16]), 64'(want(mk(16), 5)));
        chk("limit_tmo", 64'(tmo), 64'd1);
        chk("limit_txn", 64'(txn), 64'd17);

        delay = 1000;
        for (int i = 17; i <= 20; i++) req_q.push_back(mk(i));
        wait_psel("rst_mid_start");
        tick(3);
        chk("rst_mid_access", 64'(penable), 64'd1);
        nsave = got_q.size();
        rst = 1'b1;
        req_q.delete();
        tick(1);
        chk("rst_mid_psel", 64'(psel), 64'd0);
        chk("rst_mid_pen", 64'(penable), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_txn", 64'(txn), 64'd0);
        chk("rst_mid_tmo", 64'(tmo), 64'd0);
        chk("rst_mid_req", 64'(req), 64'd0);
        rst = 1'b0;
        delay = 0;
        tick(8);
        chk("rst_after_psel", 64'(psel), 64'd0);
        chk("rst_after_nresp", 64'(got_q.size()), 64'(nsave));
        chk("rst_after_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
